// File: rtl/timer_axil_slave.sv
// AXI4-Lite register file for the Timer IP: control/prescaler/auto-reload/scratch
// registers, read-only live count, W1C status, and a prescaled up-counter with interrupt.
module timer_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic                            irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [DW-1:0] CLR_MASK = {{(DW-3){1'b0}}, 3'b100};

  logic          awready_reg, bvalid_reg, arready_reg, rvalid_reg, uif_reg, irq_reg;
  logic [DW-1:0] ctrl_reg, psc_reg, arr_reg, scratch_reg, cnt_reg, pc_reg, rdata_reg;
  logic [DW-1:0] wmask, rd_mux;
  logic [2:0]    wr_idx, rd_idx;
  logic          wr_fire, clr, w1c, tick, wrap;
  logic          unused_ok;

  genvar gi;
  generate
    for (gi = 0; gi < DW/8; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{s00_axi_wstrb[gi]}};
    end
  endgenerate

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [DW-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign wr_idx    = s00_axi_awaddr[4:2];
  assign rd_idx    = s00_axi_araddr[4:2];
  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_comb begin
    wr_fire = awready_reg && s00_axi_awvalid && s00_axi_wvalid;
    clr     = wr_fire && (wr_idx == 3'd0) && s00_axi_wstrb[0] && s00_axi_wdata[2];
    w1c     = wr_fire && (wr_idx == 3'd5) && s00_axi_wstrb[0] && s00_axi_wdata[0];
    tick    = ctrl_reg[0] && (pc_reg == psc_reg);
    // >= rather than == so lowering ARR below the live count still wraps
    wrap    = tick && (cnt_reg >= arr_reg);
    rd_mux  = '0;
    case (rd_idx)
      3'd0:    rd_mux = ctrl_reg;
      3'd1:    rd_mux = psc_reg;
      3'd2:    rd_mux = arr_reg;
      3'd3:    rd_mux = scratch_reg;
      3'd4:    rd_mux = cnt_reg;
      3'd5:    rd_mux = {{(DW-1){1'b0}}, uif_reg};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      ctrl_reg    <= '0;
      psc_reg     <= '0;
      arr_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      pc_reg      <= '0;
      uif_reg     <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      awready_reg <= !awready_reg && s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg;
      if (wr_fire)
        bvalid_reg <= 1'b1;
      else if (s00_axi_bready)
        bvalid_reg <= 1'b0;

      arready_reg <= !arready_reg && s00_axi_arvalid && !rvalid_reg;
      if (arready_reg && s00_axi_arvalid) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_reg <= 1'b0;
      end

      if (wr_fire) begin
        case (wr_idx)
          3'd0: ctrl_reg    <= apply_strb(ctrl_reg, s00_axi_wdata, wmask) & ~CLR_MASK;
          3'd1: psc_reg     <= apply_strb(psc_reg, s00_axi_wdata, wmask);
          3'd2: arr_reg     <= apply_strb(arr_reg, s00_axi_wdata, wmask);
          3'd3: scratch_reg <= apply_strb(scratch_reg, s00_axi_wdata, wmask);
          default: ;
        endcase
      end

      if (clr) begin
        pc_reg  <= '0;
        cnt_reg <= '0;
      end else if (ctrl_reg[0]) begin
        if (tick) begin
          pc_reg  <= '0;
          cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
        end else begin
          pc_reg  <= pc_reg + 1'b1;
        end
      end

      // a hardware set beats a simultaneous software clear
      if (wrap && !clr)
        uif_reg <= 1'b1;
      else if (w1c)
        uif_reg <= 1'b0;

      irq_reg <= uif_reg && ctrl_reg[1];
    end
  end

  assign s00_axi_awready = awready_reg;
  assign s00_axi_wready  = awready_reg;
  assign s00_axi_bvalid  = bvalid_reg;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_reg;
  assign s00_axi_rvalid  = rvalid_reg;
  assign s00_axi_rdata   = rdata_reg;
  assign s00_axi_rresp   = 2'b00;
  assign irq             = irq_reg;
endmodule
